sav_stream: RTL and testbench

Save-RAM streaming engine that sits beside the cartridge stage, on its backup port (`bk_addr`/`bk_wr`/`bk_data`/`bk_q`). On a load request it moves 16-bit words from the bridge into cartridge RAM. On an unload request it reads cartridge RAM and streams the words out to the bridge with valid/ready backpressure. Transfer length comes from the cartridge stage's `ram_mask_file` (512-byte sectors) and is gated by `has_save`.

---
 rtl/sav_stream_pkg.sv | 10 +
 rtl/sav_skid_fifo.sv | 50 +++++
 rtl/sav_stream.sv | 89 ++++++++
 tb/tb_sav_stream.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sav_stream_pkg.sv
// sav_stream_pkg: shared FSM states, sector geometry and transfer-length helper.
package sav_stream_pkg;
  localparam int SECTOR_WORDS = 256;
  typedef enum logic [2:0] {IDLE, LOAD, UNLOAD, DRAIN, DONE} state_e;
  function automatic logic [16:0] calc_len(input logic [7:0] mask, input int sector_words);
    int n;
    n = (int'(mask) + 1) * sector_words;
    return 17'(n);
  endfunction
endpackage

// File: rtl/sav_skid_fifo.sv
// sav_skid_fifo: small synchronous FIFO with flush and occupancy count.
module sav_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q] <= din_i;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/sav_stream.sv
// sav_stream: save-RAM load/unload engine between the bridge and the cartridge RAM backup port.
module sav_stream #(
  parameter int SECTOR_WORDS = sav_stream_pkg::SECTOR_WORDS,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [7:0]  ram_mask_file,
  input  logic        has_save,
  input  logic        load_req,
  input  logic        unload_req,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [16:0] word_count,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [15:0] ld_data,
  output logic        ul_valid,
  input  logic        ul_ready,
  output logic [15:0] ul_data,
  output logic [16:0] bk_addr,
  output logic        bk_wr,
  output logic [15:0] bk_data,
  input  logic [15:0] bk_q
);
  import sav_stream_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int OW = CW + 1;
  state_e state_q;
  logic [16:0] len_q, ptr_q, cnt_q, addr_q;
  logic [15:0] wdata_q;
  logic wr_q, inflight_q, done_q;
  logic [CW-1:0] fifo_cnt;
  logic [OW-1:0] occ;
  logic fifo_empty, fifo_full, ld_hs, pop, issue;
  sav_skid_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
    .clk(clk_sys), .rst(reset), .push_i(inflight_q), .pop_i(pop), .flush_i(abort),
    .din_i(bk_q), .dout_o(ul_data), .empty_o(fifo_empty), .full_o(fifo_full), .count_o(fifo_cnt)
  );
  assign ld_ready   = state_q == LOAD;
  assign ld_hs      = ld_ready & ld_valid;
  assign ul_valid   = ~fifo_empty;
  assign pop        = ul_valid & ul_ready;
  // A pop this cycle frees a slot in time for a read issued now, keeping 1 word/cycle.
  assign occ        = OW'(fifo_cnt) + OW'(inflight_q) - OW'(pop);
  assign issue      = state_q == UNLOAD && !(fifo_full && !pop) && occ < OW'(FIFO_DEPTH);
  assign bk_addr    = issue ? ptr_q : addr_q;
  assign bk_wr      = wr_q;
  assign bk_data    = wdata_q;
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign word_count = cnt_q;
  always_ff @(posedge clk_sys) begin
    if (reset || abort) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      if (reset) begin
        len_q   <= '0;
        ptr_q   <= '0;
        cnt_q   <= '0;
        addr_q  <= '0;
        wdata_q <= '0;
      end
    end else begin
      wr_q       <= ld_hs;
      inflight_q <= issue;
      done_q     <= state_q == DONE;
      if (ld_hs) wdata_q <= ld_data;
      if (ld_hs || issue) addr_q <= ptr_q;
      if (ld_hs || issue) ptr_q <= ptr_q + 17'd1;
      if (ld_hs || pop) cnt_q <= cnt_q + 17'd1;
      case (state_q)
        IDLE: if (load_req || unload_req) begin
          len_q   <= calc_len(ram_mask_file, SECTOR_WORDS);
          ptr_q   <= '0;
          cnt_q   <= '0;
          state_q <= !has_save ? DONE : unload_req ? UNLOAD : LOAD;
        end
        LOAD:    if (ld_hs && cnt_q + 17'd1 == len_q) state_q <= DONE;
        UNLOAD:  if (issue && ptr_q + 17'd1 == len_q) state_q <= DRAIN;
        DRAIN:   if (fifo_empty && !inflight_q) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sav_stream.sv
// tb_sav_stream: randomized scenario bench for sav_stream against a cartridge-RAM model.
module tb_sav_stream;
  logic clk_sys = 1'b0;
  logic reset, has_save, load_req, unload_req, abort;
  logic [7:0] ram_mask_file;
  logic busy, done;
  logic [16:0] word_count;
  logic ld_valid, ld_ready, ul_valid, ul_ready;
  logic [15:0] ld_data, ul_data;
  logic [16:0] bk_addr;
  logic bk_wr;
  logic [15:0] bk_data, bk_q;
  logic [15:0] ram [65536];
  logic [15:0] ref_mem [65536];
  int checks, errors, wr_total, done_total, hi_addr;

  always #5 clk_sys = ~clk_sys;

  sav_stream dut (
    .clk_sys(clk_sys), .reset(reset), .ram_mask_file(ram_mask_file), .has_save(has_save),
    .load_req(load_req), .unload_req(unload_req), .abort(abort), .busy(busy), .done(done),
    .word_count(word_count), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ul_valid(ul_valid), .ul_ready(ul_ready), .ul_data(ul_data), .bk_addr(bk_addr),
    .bk_wr(bk_wr), .bk_data(bk_data), .bk_q(bk_q)
  );

  // Cartridge RAM: one-cycle read latency, write on bk_wr.
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 16'($urandom);
    forever begin
      @(posedge clk_sys);
      if (bk_wr) ram[bk_addr[15:0]] <= bk_data;
      bk_q <= ram[bk_addr[15:0]];
    end
  end

  initial begin
    wr_total = 0;
    done_total = 0;
    hi_addr = 0;
    forever begin
      @(negedge clk_sys);
      if (bk_wr === 1'b1) wr_total++;
      if (done === 1'b1) done_total++;
      if (bk_addr[16] === 1'b1) hi_addr++;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done, ld_ready, ul_valid, bk_wr} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {busy, done, ld_ready, ul_valid, bk_wr});
    end
    checks++;
    if (bk_addr !== 17'd0 || bk_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_bk: addr=%h data=%h want 0", bk_addr, bk_data);
    end
    checks++;
    if (word_count !== 17'd0 || ul_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: word_count=%h ul_data=%h want 0", word_count, ul_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_load();
    int idx, wr_seen, cyc, bad, w0, d0, bad_i;
    bit fin;
    idx = 0; wr_seen = 0; bad = 0; bad_i = 0; fin = 0;
    w0 = wr_total; d0 = done_total;
    ram_mask_file = 8'h03; has_save = 1'b1; ld_valid = 1'b1;
    ld_data = 16'($urandom); load_req = 1'b1;
    tick();
    load_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_start: busy=%b ld_ready=%b want 1 1", busy, ld_ready);
    end
    for (cyc = 0; cyc < 1200; cyc++) begin
      if (ld_ready && ld_valid) begin
        ref_mem[idx] = ld_data;
        idx++;
      end
      tick();
      if (bk_wr) begin
        if (bk_addr !== 17'(wr_seen) || bk_data !== ref_mem[wr_seen]) begin
          if (bad == 0) bad_i = wr_seen;
          bad++;
        end
        wr_seen++;
      end
      if (done) begin
        fin = 1;
        break;
      end
      ld_data = 16'($urandom);
    end
    ld_valid = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL load_timeout: no done within %0d cycles", cyc);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL load_writes: %0d bad writes, first at index %0d", bad, bad_i);
    end
    checks++;
    if (idx != 1024 || wr_seen != 1024 || wr_total - w0 != 1024) begin
      errors++;
      $display("FAIL load_count: handshakes=%0d writes=%0d pulses=%0d want 1024", idx, wr_seen, wr_total - w0);
    end
    checks++;
    if (word_count !== 17'd1024) begin
      errors++;
      $display("FAIL load_word_count: got %0d want 1024", word_count);
    end
    checks++;
    if (cyc != 1024) begin
      errors++;
      $display("FAIL load_latency: done after %0d cycles want 1024", cyc);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_total - d0 != 1) begin
      errors++;
      $display("FAIL load_done_pulse: done=%b busy=%b pulses=%0d want 0 0 1", done, busy, done_total - d0);
    end
  endtask

  task automatic test_unload(input logic [7:0] mask, input int pct, input bit both, input string name);
    int len, got, cyc, bad, stab, w0, d0, bad_i;
    logic [15:0] bad_got, bad_exp, pd;
    bit fin, pv, pr;
    len = (int'(mask) + 1) * 256;
    got = 0; bad = 0; stab = 0; bad_i = 0; fin = 0; pv = 0; pr = 0; pd = '0;
    bad_got = '0; bad_exp = '0;
    w0 = wr_total; d0 = done_total;
    ram_mask_file = mask; has_save = 1'b1;
    unload_req = 1'b1; load_req = both; ld_valid = both;
    tick();
    unload_req = 1'b0; load_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || ld_ready !== 1'b0 || bk_addr !== 17'd0) begin
      errors++;
      $display("FAIL %s_start: busy=%b ld_ready=%b bk_addr=%h want 1 0 0", name, busy, ld_ready, bk_addr);
    end
    for (cyc = 0; cyc < len * 3 + 50; cyc++) begin
      ul_ready = ($urandom_range(99) < pct);
      if (pv && !pr && (ul_valid !== 1'b1 || ul_data !== pd)) stab++;
      if (ul_valid && ul_ready) begin
        if (got >= len || ul_data !== ref_mem[got]) begin
          if (bad == 0) begin
            bad_i = got;
            bad_got = ul_data;
            bad_exp = (got < len) ? ref_mem[got] : 16'hxxxx;
          end
          bad++;
        end
        got++;
      end
      pv = ul_valid; pr = ul_ready; pd = ul_data;
      tick();
      if (done) begin
        fin = 1;
        break;
      end
    end
    ul_ready = 1'b0; ld_valid = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, cyc);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_data: %0d bad words, first idx %0d got %h want %h", name, bad, bad_i, bad_got, bad_exp);
    end
    checks++;
    if (stab != 0) begin
      errors++;
      $display("FAIL %s_stall_stable: %0d unstable stalled cycles want 0", name, stab);
    end
    checks++;
    if (got != len || word_count !== 17'(len)) begin
      errors++;
      $display("FAIL %s_count: words=%0d word_count=%0d want %0d", name, got, word_count, len);
    end
    checks++;
    if (bk_addr !== 17'(len - 1)) begin
      errors++;
      $display("FAIL %s_last_addr: got %h want %h", name, bk_addr, 17'(len - 1));
    end
    checks++;
    if (wr_total != w0) begin
      errors++;
      $display("FAIL %s_no_write: %0d bk_wr pulses want 0", name, wr_total - w0);
    end
    if (pct == 100) begin
      checks++;
      if (cyc > len + 8) begin
        errors++;
        $display("FAIL %s_throughput: %0d cycles for %0d words", name, cyc, len);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_total - d0 != 1) begin
      errors++;
      $display("FAIL %s_done_pulse: done=%b busy=%b pulses=%0d want 0 0 1", name, done, busy, done_total - d0);
    end
  endtask

  task automatic test_no_save();
    int w0;
    w0 = wr_total;
    has_save = 1'b0; ram_mask_file = 8'h07; load_req = 1'b1;
    tick();
    load_req = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL nosave_first: done=%b busy=%b want 0 1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || word_count !== 17'd0) begin
      errors++;
      $display("FAIL nosave_done: done=%b word_count=%0d want 1 0", done, word_count);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wr_total != w0) begin
      errors++;
      $display("FAIL nosave_end: done=%b busy=%b writes=%0d want 0 0 0", done, busy, wr_total - w0);
    end
    has_save = 1'b1;
  endtask

  task automatic test_abort_load();
    int w0, d0;
    w0 = wr_total; d0 = done_total;
    ram_mask_file = 8'h03; ld_valid = 1'b1; load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ld_data = 16'($urandom);
      ref_mem[i] = ld_data;
      tick();
    end
    checks++;
    if (word_count !== 17'd100) begin
      errors++;
      $display("FAIL abort_pre_count: got %0d want 100", word_count);
    end
    abort = 1'b1;
    ld_data = 16'($urandom);
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || ld_ready !== 1'b0 || bk_wr !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b ld_ready=%b bk_wr=%b want 0 0 0", busy, ld_ready, bk_wr);
    end
    repeat (3) tick();
    ld_valid = 1'b0;
    checks++;
    if (wr_total - w0 != 100 || done_total != d0 || word_count !== 17'd100) begin
      errors++;
      $display("FAIL abort_after: writes=%0d dones=%0d word_count=%0d want 100 0 100", wr_total - w0, done_total - d0, word_count);
    end
  endtask

  task automatic test_abort_unload();
    ram_mask_file = 8'h00; ul_ready = 1'b0; unload_req = 1'b1;
    tick();
    unload_req = 1'b0;
    repeat (10) tick();
    checks++;
    if (ul_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_ul_fill: ul_valid=%b want 1", ul_valid);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (ul_valid !== 1'b0 || busy !== 1'b0 || word_count !== 17'd0) begin
      errors++;
      $display("FAIL abort_ul_flush: ul_valid=%b busy=%b word_count=%0d want 0 0 0", ul_valid, busy, word_count);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = wr_total;
    ram_mask_file = 8'h00; ld_valid = 1'b1; load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_data = 16'($urandom);
      ref_mem[i] = ld_data;
      tick();
    end
    reset = 1'b1;
    tick();
    checks++;
    if (word_count !== 17'd0 || busy !== 1'b0 || bk_wr !== 1'b0 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: word_count=%0d busy=%b bk_wr=%b ld_ready=%b want 0 0 0 0", word_count, busy, bk_wr, ld_ready);
    end
    reset = 1'b0; ld_valid = 1'b0;
    tick();
    checks++;
    if (wr_total - w0 != 5) begin
      errors++;
      $display("FAIL reset_mid_writes: got %0d want 5", wr_total - w0);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; has_save = 1'b1; load_req = 1'b0; unload_req = 1'b0; abort = 1'b0;
    ram_mask_file = 8'h00; ld_valid = 1'b0; ld_data = 16'h0; ul_ready = 1'b0;
    @(posedge clk_sys);
    for (int i = 0; i < 65536; i++) ref_mem[i] = ram[i];
    test_reset();
    test_load();
    test_unload(8'h0F, 50, 1'b0, "unload");
    test_unload(8'h00, 100, 1'b1, "both_req");
    test_no_save();
    test_abort_load();
    test_abort_unload();
    test_unload(8'h01, 70, 1'b0, "post_abort");
    test_reset_mid();
    test_unload(8'hFF, 100, 1'b0, "full");
    checks++;
    if (hi_addr != 0) begin
      errors++;
      $display("FAIL addr_msb: bk_addr[16] high in %0d cycles want 0", hi_addr);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
